// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: opcodes and FSM state encoding shared by the alu_sched block.
package alu_sched_pkg;

  // Two-bit job opcodes presented on req_op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_ASH = 2'b11;

  // Sequencer states: wait for a job, compute it, hold the response
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: requester bundle plus response channel of the shared-ALU scheduler.
// slave = scheduler side, master = requesters/consumer side.
interface alu_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [2*NREQ-1:0] req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IW-1:0]     rsp_id;
  logic              rsp_flag;
  logic              busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_flag, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_flag, busy
  );

endinterface

// File: rtl/alu_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches upward from i_ptr,
// wrapping modulo NREQ (NREQ is a power of two, so index arithmetic simply
// truncates), and returns a one-hot grant plus the winning index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Candidate k is the requester k places after the pointer
  logic [IW-1:0]   w_cand [NREQ];
  logic [NREQ-1:0] w_rot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign w_cand[gi] = i_ptr + IW'(gi);
    assign w_rot[gi]  = i_req[w_cand[gi]];
  end

  // Nearest active candidate to the pointer wins; scan far-to-near so it overwrites
  always_comb begin
    o_idx   = '0;
    o_grant = '0;
    o_any   = |i_req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) o_idx = w_cand[k];
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler feeding NREQ requesters onto one sequenced
// ALU (IDLE -> EXEC -> RESP). Results carry the requester id and a
// carry/borrow/lost-bit flag.
// Build option: define ALU_SCHED_SAT_EN for saturating results (ADD/ASH/SHL
// clamp to all-ones, SUB clamps to zero when the flag is set); the flag
// always reports the raw condition. Undefined gives wrap-around results.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input logic       clk,
  input logic       rst,
  alu_sched_if.slave bus
);

  localparam int IW = $clog2(NREQ);

  // Sequencer state and round-robin pointer
  state_t        r_state;
  logic [IW-1:0] r_ptr;

  // Captured job
  logic [1:0]    r_op;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [IW-1:0] r_id;

  // Registered response
  logic          r_rsp_valid;
  logic [W-1:0]  r_rsp_data;
  logic [IW-1:0] r_rsp_id;
  logic          r_rsp_flag;
  logic          r_busy;

  // Arbitration
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;

  // Per-requester slices of the flat job buses
  logic [1:0]   w_op_arr [NREQ];
  logic [W-1:0] w_a_arr  [NREQ];
  logic [W-1:0] w_b_arr  [NREQ];

  // ALU datapath
  logic [W+1:0] w_ext;
  logic [W-1:0] w_res;
  logic         w_flag;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_op_arr[gi] = bus.req_op[2*gi+1 : 2*gi];
    assign w_a_arr[gi]  = bus.req_a[W*gi+W-1 : W*gi];
    assign w_b_arr[gi]  = bus.req_b[W*gi+W-1 : W*gi];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Only IDLE may accept; the grant is the sole combinational output
  assign bus.req_ready = (r_state == ST_IDLE) ? w_grant : '0;

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_flag  = r_rsp_flag;
  assign bus.busy      = r_busy;

  // ALU on the captured operands in W+2 bits; flag is the bit(s) lost from the low W
  always_comb begin
    w_ext  = '0;
    w_flag = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_ext  = {2'b00, r_a} + {2'b00, r_b};
        w_flag = w_ext[W];
      end
      OP_SUB: begin
        w_ext  = {2'b00, r_a} - {2'b00, r_b};
        w_flag = (r_a < r_b);
      end
      OP_SHL: begin
        w_ext  = {1'b0, r_a, 1'b0};
        w_flag = r_a[W-1];
      end
      default: begin
        w_ext  = ({2'b00, r_a} + {2'b00, r_b}) << 1;
        w_flag = |w_ext[W+1:W];
      end
    endcase
    w_res = w_ext[W-1:0];
`ifdef ALU_SCHED_SAT_EN
    if (w_flag) w_res = (r_op == OP_SUB) ? '0 : '1;
`endif
  end

  // Sequencer: accept a job, compute it, hold the response until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_flag  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_op    <= w_op_arr[w_idx];
            r_a     <= w_a_arr[w_idx];
            r_b     <= w_b_arr[w_idx];
            r_id    <= w_idx;
            r_busy  <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_res;
          r_rsp_flag  <= w_flag;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            // Move past the served requester so it cannot win twice in a row
            r_ptr       <= r_id + IW'(1);
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized + directed bench for alu_sched with a queue-based
// scoreboard. A negedge monitor holds a cycle-level reference (round-robin
// pick from a pointer, fixed 3-cycle job timeline, integer ALU arithmetic).
`timescale 1ns/1ps
module tb_alu_sched;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requester-side drive state
  logic       v  [NREQ];
  logic [1:0] op [NREQ];
  logic [7:0] a  [NREQ];
  logic [7:0] b  [NREQ];
  logic       rsp_ready_drv;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]       = v[i];
      bus.req_op[2*i +: 2]   = op[i];
      bus.req_a[8*i +: 8]    = a[i];
      bus.req_b[8*i +: 8]    = b[i];
    end
    bus.rsp_ready = rsp_ready_drv;
  end

  typedef struct {
    int data;
    int id;
    int flag;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   acc_cnt [NREQ];
  int   seen    [NREQ];

  // Reference model state: 0 idle, 1 computing, 2 responding
  int m_phase = 0;
  int m_ptr   = 0;
  int m_id    = 0;
  bit just_reset = 1'b0;

  function automatic exp_t ref_job(int o, int x, int y, int id);
    exp_t e;
    int   s;
    e.id = id;
    case (o)
      0: begin s = x + y;       e.flag = (s > 255) ? 1 : 0;  e.data = s % 256; end
      1: begin                  e.flag = (x < y) ? 1 : 0;    e.data = (x - y + 256) % 256; end
      2: begin s = x * 2;       e.flag = (x >= 128) ? 1 : 0; e.data = s % 256; end
      default: begin s = (x + y) * 2; e.flag = (s >= 256) ? 1 : 0; e.data = s % 256; end
    endcase
`ifdef ALU_SCHED_SAT_EN
    if (e.flag == 1) e.data = (o == 1) ? 0 : 255;
`endif
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor/model: check every cycle, push expectations on accept, pop on handshake
  always @(negedge clk) begin
    int w;
    int j;
    int exp_rr;
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      exp_q.delete();
      just_reset = 1'b1;
    end else begin
      w = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (w < 0 && v[j]) w = j;
        end
      end
      exp_rr = (w >= 0) ? (1 << w) : 0;
      chk("req_ready", int'(bus.req_ready), exp_rr);
      chk("busy", int'(bus.busy), (m_phase != 0) ? 1 : 0);
      chk("rsp_valid", int'(bus.rsp_valid), (m_phase == 2) ? 1 : 0);
      if (just_reset) begin
        chk("reset_rsp_data", int'(bus.rsp_data), 0);
        chk("reset_rsp_id", int'(bus.rsp_id), 0);
        chk("reset_rsp_flag", int'(bus.rsp_flag), 0);
        just_reset = 1'b0;
      end
      if (m_phase == 2) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_depth", exp_q.size(), 1);
        end else begin
          chk("rsp_data", int'(bus.rsp_data), exp_q[0].data);
          chk("rsp_id", int'(bus.rsp_id), exp_q[0].id);
          chk("rsp_flag", int'(bus.rsp_flag), exp_q[0].flag);
        end
      end
      case (m_phase)
        0: begin
          if (w >= 0) begin
            exp_q.push_back(ref_job(int'(op[w]), int'(a[w]), int'(b[w]), w));
            acc_cnt[w] = acc_cnt[w] + 1;
            m_id    = w;
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: begin
          if (rsp_ready_drv) begin
            if (exp_q.size() != 0) begin
              $display("[TB] rsp id=%0d data=%02h flag=%0d (expected id=%0d data=%02h flag=%0d)",
                       bus.rsp_id, bus.rsp_data, bus.rsp_flag,
                       exp_q[0].id, exp_q[0].data, exp_q[0].flag);
              void'(exp_q.pop_front());
            end
            m_ptr   = (m_id + 1) % NREQ;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(int i, int o, int x, int y);
    op[i] = o[1:0];
    a[i]  = x[7:0];
    b[i]  = y[7:0];
    v[i]  = 1'b1;
  endtask

  // Hold requester i valid until the model records its acceptance, then drop it
  task automatic wait_acc(int i, int base);
    int n;
    n = 0;
    while (acc_cnt[i] == base && n < 60) begin
      tick();
      n++;
    end
    tests++;
    if (acc_cnt[i] == base) begin
      fails++;
      $display("FAIL accept_timeout req%0d: got 0 accepts expected 1", i);
    end
    v[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_phase != 0 || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (m_phase != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL idle_timeout: got phase %0d expected 0", m_phase);
    end
  endtask

  initial begin
    int base;
    int base3;
    int got;
    int n;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = 1'b0; op[i] = 2'b00; a[i] = 8'h00; b[i] = 8'h00;
      acc_cnt[i] = 0; seen[i] = 0;
    end
    rsp_ready_drv = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Single job on requester 2
    base = acc_cnt[2]; issue(2, 0, 'h30, 'h12); wait_acc(2, base); wait_idle();

    // Overflow cases
    base = acc_cnt[0]; issue(0, 0, 'hF0, 'h20); wait_acc(0, base); wait_idle();
    base = acc_cnt[1]; issue(1, 1, 'h05, 'h07); wait_acc(1, base); wait_idle();

    // Round-robin with all four continuously requesting
    for (int i = 0; i < NREQ; i++) begin
      seen[i] = acc_cnt[i];
      issue(i, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    got = 0; n = 0;
    while (got < 8 && n < 200) begin
      tick();
      n++;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          got++;
          issue(i, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
    end
    chk("rr_accept_count", got, 8);
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    wait_idle();

    // Backpressure on SHL, with a withdrawn request and a late ASH request meanwhile
    rsp_ready_drv = 1'b0;
    base = acc_cnt[0]; issue(0, 2, 'h81, 0); wait_acc(0, base);
    tick(2);
    base = acc_cnt[1]; issue(1, 0, 'h11, 'h22);
    tick(1);
    v[1] = 1'b0;
    base3 = acc_cnt[3]; issue(3, 3, 'h40, 'h40);
    tick(3);
    rsp_ready_drv = 1'b1;
    wait_acc(3, base3);
    wait_idle();
    chk("withdrawn_req1_accepts", acc_cnt[1], base);

    // Mid-operation reset: pointer must return to 0
    base = acc_cnt[2]; issue(2, 0, 1, 2); wait_acc(2, base); wait_idle();
    base = acc_cnt[1]; issue(1, 0, 5, 6); wait_acc(1, base);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    base = acc_cnt[0]; base3 = acc_cnt[3];
    issue(0, 1, 'h80, 'h01); issue(3, 0, 'h01, 'h01);
    wait_acc(0, base); wait_acc(3, base3); wait_idle();

    // Randomized traffic with backpressure, withdrawals and occasional resets
    for (int i = 0; i < NREQ; i++) seen[i] = acc_cnt[i];
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_cnt[i] != seen[i]) begin
          seen[i] = acc_cnt[i];
          v[i] = 1'b0;
        end else if (!v[i]) begin
          if ($urandom_range(0, 9) < 4)
            issue(i, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
        end else if ($urandom_range(0, 19) == 0) begin
          v[i] = 1'b0;
        end
      end
      rsp_ready_drv = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    rst = 1'b0;
    rsp_ready_drv = 1'b1;
    wait_idle();
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Shared-ALU job scheduler: arbitrates up to NREQ requesters, each submitting one 8-bit two-operand job (add, subtract, shift, add-then-shift), onto a single sequenced ALU datapath. Jobs are granted round-robin, executed in the block's own load/execute/respond state machine, and returned with the winning requester's ID and a carry/overflow flag. It sits between the control FSMs that need arithmetic and the one ALU the team budgets per cluster.

## Interface
- NREQ, 4, number of requesters; power of two, 2..8
- W, 8, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_op  in  NREQ*2  per-requester opcode, slice i = [2i+1:2i]
- req_a  in  NREQ*W  operand A, slice i = [W*i+W-1:W*i]
- req_b  in  NREQ*W  operand B, same slicing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_data  out  W  result
- rsp_id  out  $clog2(NREQ)  requester index of result
- rsp_flag  out  1  carry/borrow/lost-bit indicator
- busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: round-robin search from rr_ptr upward, wrapping mod NREQ; first i with req_valid[i] wins; req_ready[i]=1 combinationally that cycle, all others 0. On accept, capture op/a/b/i into operand registers, go to EXEC. No valid request: stay IDLE, req_ready=0.
- EXEC: compute one result into result register; go to RESP. req_ready=0.
- RESP: rsp_valid=1, outputs held stable; on rsp_valid&rsp_ready go to IDLE, rr_ptr <= (id+1) mod NREQ. req_ready=0.
- Opcodes (W+2-bit internal math, result = low W bits):
  - 00 ADD: a+b; flag = carry out.
  - 01 SUB: a-b; flag = borrow (a<b).
  - 10 SHL: a<<1; flag = a[W-1].
  - 11 ASH: (a+b)<<1; flag = OR of bits above W-1 of the (W+2)-bit value.
- Requesters hold valid/op/a/b stable until ready; dropping valid before ready is legal, arbitration re-evaluated every IDLE cycle.
- A requester re-requesting immediately after its response loses to any other valid requester (rr_ptr moved past it).
- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_flag 0, busy 0.
- rst asserted in any state: return to reset values next edge; in-flight job dropped, no response emitted.

## Timing
- Accept at edge t (IDLE, valid&ready); EXEC during cycle t+1; rsp_valid high from cycle t+2.
- Minimum job period 3 cycles (accept, EXEC, RESP with rsp_ready=1); no accept in the same cycle as a response handshake.
- rsp_ready low stalls in RESP indefinitely; all rsp_* stable while stalled.
- req_ready is the only combinational output (from req_valid, rr_ptr, state); all others registered.

## Configuration
- ALU_SCHED_SAT_EN defined: saturating results — ADD and ASH yield all-ones when flag=1, SUB yields 0 when flag=1, SHL yields all-ones when flag=1; rsp_flag still reports the raw condition.
- Undefined: wrap-around results (low W bits), flag as above.

## Structure
- Package alu_sched_pkg: opcode localparams (OP_ADD, OP_SUB, OP_SHL, OP_ASH), state enum typedef, state encodings.
- Sub-module rr_arbiter (NREQ request vector + pointer in, one-hot grant + index out), purely combinational; pointer register lives in alu_sched.

## Test plan
- Single job: req 2 valid, op ADD, a=0x30, b=0x12 -> req_ready=0b0100 same cycle; rsp at t+2: data 0x42, id 2, flag 0.
- Overflow: op ADD a=0xF0 b=0x20 -> data 0x10 flag 1 (SAT_EN: 0xFF flag 1); op SUB a=0x05 b=0x07 -> 0xFE flag 1 (SAT_EN: 0x00).
- Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles on op SHL a=0x81 -> rsp_valid and data 0x02 flag 1 held 5 cycles, req_ready stays 0, busy 1.
- Valid withdrawal: req 1 valid one IDLE cycle then dropped while req 3 rises -> only req 3 accepted, ASH a=0x40 b=0x40 -> data 0x00 flag 1.
- Mid-op reset: rst in EXEC -> next cycle IDLE, rsp_valid 0, busy 0, rr_ptr 0; no response for dropped job.
